// File: rtl/alu_issue.sv
// alu_issue: decode-to-execute issue stage.
// Decodes an integer instruction into ALU operands, command and write-back
// controls, forwards the result of the instruction currently in EX, and
// registers everything into the EX stage with stall/flush control.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [4:0]  rs_idx,
    input  logic [4:0]  rt_idx,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] alu_result,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_cmd,
    output logic [4:0]  ex_dest,
    output logic        ex_wb_en,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_illegal,
    output logic [31:0] issue_count
);

    // ALU command encodings
    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;

    // Major opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    // EX stage registers
    logic        ex_valid_reg;
    logic [31:0] alu_in1_reg;
    logic [31:0] alu_in2_reg;
    logic [3:0]  alu_cmd_reg;
    logic [4:0]  ex_dest_reg;
    logic        ex_wb_en_reg;
    logic        ex_mem_rd_reg;
    logic        ex_mem_wr_reg;
    logic        ex_illegal_reg;
    logic [31:0] issue_count_reg;

    // Decoded values for the instruction in ID
    logic [31:0] alu_in1_next;
    logic [31:0] alu_in2_next;
    logic [3:0]  alu_cmd_next;
    logic [4:0]  ex_dest_next;
    logic        ex_wb_en_next;
    logic        ex_mem_rd_next;
    logic        ex_mem_wr_next;
    logic        ex_illegal_next;
    logic        legal;

    // Forwarding: source 0 is rs, source 1 is rt. A producer in EX can
    // forward only if it writes a register and is not a load (a load's
    // value is not available from the ALU).
    logic        fwd_en;
    logic [4:0]  src_idx [2];
    logic [31:0] src_val [2];
    logic [31:0] opnd    [2];

    assign fwd_en     = ex_valid_reg & ex_wb_en_reg & ~ex_mem_rd_reg;
    assign src_idx[0] = rs_idx;
    assign src_idx[1] = rt_idx;
    assign src_val[0] = rs_val;
    assign src_val[1] = rt_val;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            // Register 0 is hard-wired, so it is never a forwarding target.
            assign opnd[gi] = (fwd_en && (src_idx[gi] != 5'd0) &&
                               (src_idx[gi] == ex_dest_reg)) ? alu_result
                                                             : src_val[gi];
        end
    endgenerate

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'b0, imm};

    // Instruction decode into operands, command and write-back controls
    always_comb begin
        alu_in1_next   = opnd[0];
        alu_in2_next   = opnd[1];
        alu_cmd_next   = CMD_ADD;
        ex_dest_next   = rt_idx;
        ex_mem_rd_next = 1'b0;
        ex_mem_wr_next = 1'b0;
        legal          = 1'b1;

        case (opcode)
            OP_RTYPE: begin
                ex_dest_next = rd_idx;
                case (funct)
                    FN_ADD, FN_ADDU: alu_cmd_next = CMD_ADD;
                    FN_SUB, FN_SUBU: alu_cmd_next = CMD_SUB;
                    FN_AND:          alu_cmd_next = CMD_AND;
                    FN_OR:           alu_cmd_next = CMD_OR;
                    FN_XOR:          alu_cmd_next = CMD_XOR;
                    FN_NOR:          alu_cmd_next = CMD_NOR;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        alu_in1_next = opnd[1];
                        alu_in2_next = {27'b0, shamt};
                        alu_cmd_next = (funct == FN_SLL) ? CMD_SLL :
                                       (funct == FN_SRL) ? CMD_SRL : CMD_SRA;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        // Shift amount comes from rs, so it may be forwarded.
                        alu_in1_next = opnd[1];
                        alu_in2_next = {27'b0, opnd[0][4:0]};
                        alu_cmd_next = (funct == FN_SLLV) ? CMD_SLL :
                                       (funct == FN_SRLV) ? CMD_SRL : CMD_SRA;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_in2_next = imm_sext;
                alu_cmd_next = CMD_ADD;
            end
            OP_ANDI: begin
                alu_in2_next = imm_zext;
                alu_cmd_next = CMD_AND;
            end
            OP_ORI: begin
                alu_in2_next = imm_zext;
                alu_cmd_next = CMD_OR;
            end
            OP_XORI: begin
                alu_in2_next = imm_zext;
                alu_cmd_next = CMD_XOR;
            end
            OP_LW: begin
                alu_in2_next   = imm_sext;
                alu_cmd_next   = CMD_ADD;
                ex_mem_rd_next = 1'b1;
            end
            OP_SW: begin
                alu_in2_next   = imm_sext;
                alu_cmd_next   = CMD_ADD;
                ex_mem_wr_next = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        // Unsupported encodings carry no side effects into EX.
        if (!legal) begin
            alu_cmd_next   = CMD_ADD;
            ex_mem_rd_next = 1'b0;
            ex_mem_wr_next = 1'b0;
        end

        ex_illegal_next = ~legal;
        ex_wb_en_next   = legal & ~ex_mem_wr_next & (ex_dest_next != 5'd0);
    end

    // A new instruction enters EX only when not stalled, not flushed and valid.
    logic load_insn;
    logic load_bubble;
    assign load_insn   = id_valid & ~stall & ~flush;
    assign load_bubble = flush | (~stall & ~id_valid);

    // EX stage register with stall hold, flush/idle bubble and issue counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_reg    <= 1'b0;
            alu_in1_reg     <= 32'd0;
            alu_in2_reg     <= 32'd0;
            alu_cmd_reg     <= 4'd0;
            ex_dest_reg     <= 5'd0;
            ex_wb_en_reg    <= 1'b0;
            ex_mem_rd_reg   <= 1'b0;
            ex_mem_wr_reg   <= 1'b0;
            ex_illegal_reg  <= 1'b0;
            issue_count_reg <= 32'd0;
        end else if (load_bubble) begin
            // Operand fields are left as they are; only the controls matter.
            ex_valid_reg   <= 1'b0;
            ex_wb_en_reg   <= 1'b0;
            ex_mem_rd_reg  <= 1'b0;
            ex_mem_wr_reg  <= 1'b0;
            ex_illegal_reg <= 1'b0;
        end else if (load_insn) begin
            ex_valid_reg    <= 1'b1;
            alu_in1_reg     <= alu_in1_next;
            alu_in2_reg     <= alu_in2_next;
            alu_cmd_reg     <= alu_cmd_next;
            ex_dest_reg     <= ex_dest_next;
            ex_wb_en_reg    <= ex_wb_en_next;
            ex_mem_rd_reg   <= ex_mem_rd_next;
            ex_mem_wr_reg   <= ex_mem_wr_next;
            ex_illegal_reg  <= ex_illegal_next;
            issue_count_reg <= issue_count_reg + 32'd1;
        end
    end

    assign ex_valid    = ex_valid_reg;
    assign alu_in1     = alu_in1_reg;
    assign alu_in2     = alu_in2_reg;
    assign alu_cmd     = alu_cmd_reg;
    assign ex_dest     = ex_dest_reg;
    assign ex_wb_en    = ex_wb_en_reg;
    assign ex_mem_rd   = ex_mem_rd_reg;
    assign ex_mem_wr   = ex_mem_wr_reg;
    assign ex_illegal  = ex_illegal_reg;
    assign issue_count = issue_count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed checks of the alu_issue stage.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [31:0] rs_val, rt_val, alu_result;
    logic        stall, flush;
    logic        ex_valid;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_cmd;
    logic [4:0]  ex_dest;
    logic        ex_wb_en, ex_mem_rd, ex_mem_wr, ex_illegal;
    logic [31:0] issue_count;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] exp_count;

    wire [4:0]   flags   = {ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_illegal};
    wire [109:0] all_out = {ex_valid, alu_in1, alu_in2, alu_cmd, ex_dest,
                            ex_wb_en, ex_mem_rd, ex_mem_wr, ex_illegal, issue_count};

    alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .opcode     (opcode),
        .funct      (funct),
        .shamt      (shamt),
        .imm        (imm),
        .rs_idx     (rs_idx),
        .rt_idx     (rt_idx),
        .rd_idx     (rd_idx),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .alu_result (alu_result),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_cmd    (alu_cmd),
        .ex_dest    (ex_dest),
        .ex_wb_en   (ex_wb_en),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_illegal (ex_illegal),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name);
        $display("[%0t] %-10s valid=%0b cmd=%b in1=%h in2=%h dest=%0d wb=%0b rd=%0b wr=%0b ill=%0b cnt=%0d",
                 $time, name, ex_valid, alu_cmd, alu_in1, alu_in2, ex_dest,
                 ex_wb_en, ex_mem_rd, ex_mem_wr, ex_illegal, issue_count);
    endtask

    task automatic idle();
        id_valid = 0; stall = 0; flush = 0;
        opcode = 0; funct = 0; shamt = 0; imm = 0;
        rs_idx = 0; rt_idx = 0; rd_idx = 0;
        rs_val = 0; rt_val = 0; alu_result = 0;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [4:0] rs_i, input logic [4:0] rt_i,
                         input logic [4:0] rd_i, input logic [4:0] sh,
                         input logic [31:0] rsv, input logic [31:0] rtv);
        id_valid = 1; opcode = 6'b000000; funct = f; shamt = sh;
        imm = {rd_i, sh, f};
        rs_idx = rs_i; rt_idx = rt_i; rd_idx = rd_i; rs_val = rsv; rt_val = rtv;
    endtask

    task automatic itype(input logic [5:0] op, input logic [4:0] rs_i, input logic [4:0] rt_i,
                         input logic [15:0] im, input logic [31:0] rsv, input logic [31:0] rtv);
        id_valid = 1; opcode = op; imm = im;
        funct = im[5:0]; shamt = im[10:6]; rd_idx = im[15:11];
        rs_idx = rs_i; rt_idx = rt_i; rs_val = rsv; rt_val = rtv;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        itype(6'b001000, 1, 2, 16'h0001, 32'h5, 32'h0);
        step(); step();
        show("reset");
        checks++; if (all_out !== 110'd0) $display("FAIL reset_outputs got %h need 0", all_out); else passed++;
        idle();
        rst = 1;
        step();
        exp_count = 0;
        show("post_rst");
        checks++; if ({flags, issue_count} !== {5'b00000, exp_count}) $display("FAIL idle_after_reset got %b/%0d need 00000/%0d", flags, issue_count, exp_count); else passed++;
    endtask

    task automatic test_immediates();
        itype(6'b001000, 1, 2, 16'hFFFE, 32'd5, 32'h99);
        step(); exp_count++;
        show("addi");
        checks++; if ({alu_in1, alu_in2} !== {32'd5, 32'hFFFFFFFE}) $display("FAIL addi_ops got %h %h need 00000005 fffffffe", alu_in1, alu_in2); else passed++;
        checks++; if ({alu_cmd, ex_dest, flags} !== {4'b0000, 5'd2, 5'b11000}) $display("FAIL addi_ctl got %b %0d %b need 0000 2 11000", alu_cmd, ex_dest, flags); else passed++;
        checks++; if (issue_count !== exp_count) $display("FAIL addi_count got %0d need %0d", issue_count, exp_count); else passed++;

        itype(6'b001100, 3, 4, 16'h8001, 32'hFFFF0000, 32'h0);
        step(); exp_count++;
        show("andi");
        checks++; if ({alu_in1, alu_in2, alu_cmd, ex_dest} !== {32'hFFFF0000, 32'h00008001, 4'b0100, 5'd4}) $display("FAIL andi got %h %h %b %0d need ffff0000 00008001 0100 4", alu_in1, alu_in2, alu_cmd, ex_dest); else passed++;

        itype(6'b001110, 9, 10, 16'hF00F, 32'd1, 32'h0);
        step(); exp_count++;
        show("xori");
        checks++; if ({alu_in2, alu_cmd, ex_dest, issue_count} !== {32'h0000F00F, 4'b0111, 5'd10, exp_count}) $display("FAIL xori got %h %b %0d %0d need 0000f00f 0111 10 %0d", alu_in2, alu_cmd, ex_dest, issue_count, exp_count); else passed++;
    endtask

    task automatic test_shifts();
        rtype(6'b000011, 6, 7, 5, 5'd4, 32'h123, 32'h80000000);
        step(); exp_count++;
        show("sra");
        checks++; if ({alu_in1, alu_in2, alu_cmd} !== {32'h80000000, 32'd4, 4'b1001}) $display("FAIL sra got %h %h %b need 80000000 00000004 1001", alu_in1, alu_in2, alu_cmd); else passed++;
        checks++; if ({ex_dest, flags} !== {5'd5, 5'b11000}) $display("FAIL sra_ctl got %0d %b need 5 11000", ex_dest, flags); else passed++;

        rtype(6'b000111, 11, 12, 13, 5'd9, 32'h25, 32'hF0);
        step(); exp_count++;
        show("srav");
        checks++; if ({alu_in1, alu_in2, alu_cmd, ex_dest} !== {32'hF0, 32'd5, 4'b1001, 5'd13}) $display("FAIL srav got %h %h %b %0d need 000000f0 00000005 1001 13", alu_in1, alu_in2, alu_cmd, ex_dest); else passed++;

        // rs = r13 is produced by the srav in EX: shift amount comes from alu_result
        rtype(6'b000100, 13, 14, 15, 5'd0, 32'h1F, 32'h1);
        alu_result = 32'h43;
        step(); exp_count++;
        show("sllv_fwd");
        checks++; if ({alu_in1, alu_in2, alu_cmd} !== {32'h1, 32'd3, 4'b1000}) $display("FAIL sllv_fwd got %h %h %b need 00000001 00000003 1000", alu_in1, alu_in2, alu_cmd); else passed++;
    endtask

    task automatic test_mem();
        itype(6'b100011, 16, 8, 16'hFFFC, 32'd100, 32'h0);
        alu_result = 0;
        step(); exp_count++;
        show("lw");
        checks++; if ({alu_in1, alu_in2, alu_cmd, ex_dest, flags} !== {32'd100, 32'hFFFFFFFC, 4'b0000, 5'd8, 5'b11100}) $display("FAIL lw got %h %h %b %0d %b need 00000064 fffffffc 0000 8 11100", alu_in1, alu_in2, alu_cmd, ex_dest, flags); else passed++;

        // Load in EX targets r8: must not forward into the store's rs
        itype(6'b101011, 8, 17, 16'h0010, 32'h200, 32'h0);
        alu_result = 32'hDEAD;
        step(); exp_count++;
        show("sw");
        checks++; if ({alu_in1, alu_in2, flags} !== {32'h200, 32'h10, 5'b10010}) $display("FAIL sw got %h %h %b need 00000200 00000010 10010", alu_in1, alu_in2, flags); else passed++;
    endtask

    task automatic test_back_to_back();
        rtype(6'b100000, 1, 2, 3, 5'd0, 32'd10, 32'd20);
        alu_result = 0;
        step(); exp_count++;
        show("add_r3");
        checks++; if ({alu_in1, alu_in2, alu_cmd, ex_dest, flags} !== {32'd10, 32'd20, 4'b0000, 5'd3, 5'b11000}) $display("FAIL add_r3 got %h %h %b %0d %b need 0000000a 00000014 0000 3 11000", alu_in1, alu_in2, alu_cmd, ex_dest, flags); else passed++;

        rtype(6'b100010, 3, 3, 4, 5'd0, 32'd0, 32'd0);
        alu_result = 32'd7;
        step(); exp_count++;
        show("sub_fwd");
        checks++; if ({alu_in1, alu_in2, alu_cmd} !== {32'd7, 32'd7, 4'b0010}) $display("FAIL sub_fwd got %h %h %b need 00000007 00000007 0010", alu_in1, alu_in2, alu_cmd); else passed++;

        // rt-only forward; destination r0 gives no write-back
        rtype(6'b100111, 5, 4, 0, 5'd0, 32'hAA, 32'h0);
        alu_result = 32'h55;
        step(); exp_count++;
        show("nor_rt");
        checks++; if ({alu_in1, alu_in2, alu_cmd, flags} !== {32'hAA, 32'h55, 4'b0110, 5'b10000}) $display("FAIL nor_rt got %h %h %b %b need 000000aa 00000055 0110 10000", alu_in1, alu_in2, alu_cmd, flags); else passed++;

        // Producer wrote r0 without wb: index 0 is not forwarded
        rtype(6'b100101, 0, 0, 6, 5'd0, 32'd1, 32'd2);
        alu_result = 32'hFF;
        step(); exp_count++;
        show("or_r0");
        checks++; if ({alu_in1, alu_in2, alu_cmd, issue_count} !== {32'd1, 32'd2, 4'b0101, exp_count}) $display("FAIL or_r0 got %h %h %b %0d need 00000001 00000002 0101 %0d", alu_in1, alu_in2, alu_cmd, issue_count, exp_count); else passed++;
    endtask

    task automatic test_stall_flush();
        alu_result = 0;
        rtype(6'b100110, 1, 2, 3, 5'd0, 32'h1, 32'h2);
        stall = 1; flush = 1;
        step();
        show("stl+fls");
        checks++; if ({flags, issue_count} !== {5'b00000, exp_count}) $display("FAIL stall_flush got %b/%0d need 00000/%0d", flags, issue_count, exp_count); else passed++;

        stall = 0; flush = 0;
        rtype(6'b100110, 1, 2, 9, 5'd0, 32'h0F, 32'hF0);
        step(); exp_count++;
        show("xor");
        checks++; if ({alu_in1, alu_in2, alu_cmd, ex_dest, issue_count} !== {32'h0F, 32'hF0, 4'b0111, 5'd9, exp_count}) $display("FAIL xor got %h %h %b %0d %0d", alu_in1, alu_in2, alu_cmd, ex_dest, issue_count); else passed++;

        stall = 1;
        rtype(6'b100000, 3, 4, 5, 5'd0, 32'd1, 32'd2);
        for (int i = 0; i < 2; i++) begin
            step();
            show("stall");
            checks++; if (all_out !== {1'b1, 32'h0F, 32'hF0, 4'b0111, 5'd9, 4'b1000, exp_count}) $display("FAIL stall_hold%0d got %h", i, all_out); else passed++;
        end

        idle();
        step();
        show("bubble");
        checks++; if ({flags, issue_count} !== {5'b00000, exp_count}) $display("FAIL idle_bubble got %b/%0d need 00000/%0d", flags, issue_count, exp_count); else passed++;
    endtask

    task automatic test_wrap();
        force dut.issue_count_reg = 32'hFFFFFFFF;
        #1;
        release dut.issue_count_reg;
        itype(6'b001001, 1, 2, 16'h0003, 32'd4, 32'd0);
        step();
        exp_count = 32'd0;
        show("wrap");
        checks++; if ({ex_valid, issue_count} !== {1'b1, exp_count}) $display("FAIL wrap got %b/%h need 1/00000000", ex_valid, issue_count); else passed++;
        step(); exp_count++;
        show("post_wrap");
        checks++; if (issue_count !== exp_count) $display("FAIL post_wrap got %0d need %0d", issue_count, exp_count); else passed++;
    endtask

    task automatic test_illegal_reset();
        itype(6'b111111, 1, 2, 16'h1234, 32'd5, 32'd6);
        step(); exp_count++;
        show("ill_op");
        checks++; if ({alu_cmd, flags, issue_count} !== {4'b0000, 5'b10001, exp_count}) $display("FAIL illegal_op got %b %b %0d need 0000 10001 %0d", alu_cmd, flags, issue_count, exp_count); else passed++;

        rtype(6'b001000, 1, 2, 3, 5'd0, 32'd5, 32'd6);
        step(); exp_count++;
        show("ill_fn");
        checks++; if ({alu_cmd, flags} !== {4'b0000, 5'b10001}) $display("FAIL illegal_funct got %b %b need 0000 10001", alu_cmd, flags); else passed++;

        // Assert reset between edges with an illegal instruction in flight
        #2;
        rst = 0;
        #1;
        show("async_rst");
        checks++; if (all_out !== 110'd0) $display("FAIL async_reset got %h need 0", all_out); else passed++;
        idle();
        #2;
        rst = 1;
        exp_count = 0;
        step();
        checks++; if ({flags, issue_count} !== {5'b00000, exp_count}) $display("FAIL discard_inflight got %b/%0d need 00000/0", flags, issue_count); else passed++;

        itype(6'b001101, 2, 3, 16'h00F0, 32'h0F, 32'd0);
        step(); exp_count++;
        show("ori");
        checks++; if ({alu_in1, alu_in2, alu_cmd, flags, issue_count} !== {32'h0F, 32'hF0, 4'b0101, 5'b11000, exp_count}) $display("FAIL first_after_reset got %h %h %b %b %0d", alu_in1, alu_in2, alu_cmd, flags, issue_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_immediates();
        test_shifts();
        test_mem();
        test_back_to_back();
        test_stall_flush();
        test_wrap();
        test_illegal_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- id_valid  in  1  decode stage presents an instruction
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- shamt  in  5  instruction[10:6]
- imm  in  16  instruction[15:0]
- rs_idx, rt_idx, rd_idx  in  5 each  register indices
- rs_val, rt_val  in  32 each  register-file read data
- alu_result  in  32  combinational ALU output for the instruction now in EX
- stall  in  1  hold EX register
- flush  in  1  squash the instruction entering EX
- ex_valid  out  1  EX holds a valid instruction
- alu_in1, alu_in2  out  32 each  ALU operands
- alu_cmd  out  4  ALU command
- ex_dest  out  5  write-back register
- ex_wb_en  out  1  write-back enable
- ex_mem_rd, ex_mem_wr  out  1 each  load / store marker
- ex_illegal  out  1  unsupported encoding
- issue_count  out  32  valid instructions issued

Function
REQ-003 All outputs SHALL be registered; an instruction sampled at edge N SHALL appear on the outputs after edge N (latency 1).
REQ-004 alu_cmd encoding SHALL be: add 0000, sub 0010, and 0100, or 0101, nor 0110, xor 0111, sll 1000, sra 1001, srl 1010.
REQ-005 R-type (opcode 000000) SHALL decode funct as follows:
- 100000/100001 add
- 100010/100011 sub
- 100100 and
- 100101 or
- 100110 xor
- 100111 nor
- 000000/000010/000011 sll/srl/sra: in1=rt, in2={27'b0,shamt}
- 000100/000110/000111 sllv/srlv/srav: in1=rt, in2={27'b0,rs[4:0]}
- all other R-type: in1=rs, in2=rt, dest=rd
REQ-006 I-type SHALL decode as follows, with in1=rs and dest=rt:
- 001000/001001 add, in2=sign-extended imm
- 001100 and, in2=zero-extended imm
- 001101 or, in2=zero-extended imm
- 001110 xor, in2=zero-extended imm
- 100011 lw: add, sign-extended imm, ex_mem_rd=1
- 101011 sw: add, sign-extended imm, ex_mem_wr=1, ex_wb_en=0
REQ-007 Any other opcode or funct SHALL register ex_illegal=1, alu_cmd=0000, ex_wb_en=0, ex_mem_rd=0, ex_mem_wr=0, with ex_valid following id_valid.
REQ-008 ex_wb_en SHALL be 1 only for legal non-store instructions with dest≠0.
REQ-009 Forwarding rule: when ex_valid=1, ex_wb_en=1, ex_mem_rd=0 and ex_dest equals rs_idx (or rt_idx), the block SHALL use alu_result in place of rs_val (or rt_val), including for the variable-shift amount. Index 0 is never forwarded.
REQ-010 stall=1 SHALL hold every EX register and issue_count unchanged.
REQ-011 flush=1 SHALL load a bubble: ex_valid=0, ex_wb_en=0, ex_mem_rd=0, ex_mem_wr=0, ex_illegal=0; operand registers are don't-care. flush SHALL win over stall.
REQ-012 id_valid=0 (no stall, no flush) SHALL load a bubble as in REQ-011.
REQ-013 issue_count SHALL increment by 1 on each edge that loads ex_valid=1, including illegal instructions, and SHALL wrap from FFFFFFFF to 0.

Reset
REQ-014 While rst=0, all outputs and internal registers SHALL be 0 immediately, independent of clk.
REQ-015 After rst deasserts, the first edge with id_valid=1 SHALL issue normally. An instruction in flight when reset asserts SHALL be discarded.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- addi: opcode 001000, rs_val=5, imm=FFFE -> next cycle in1=5, in2=FFFFFFFE, cmd 0000, dest=rt, wb_en=1
- sra: funct 000011, rt_val=80000000, shamt=4 -> in1=80000000, in2=4, cmd 1001
- back-to-back: add r3; then sub using r3 with rs_val=0 and alu_result=7 -> sub in1=7
- stall+flush together with ex_valid=1 -> ex_valid=0 and issue_count unchanged; stall alone -> all outputs held
- issue_count preset by 2^32-1 issues (or forced) plus one issue -> 0
- opcode 111111 -> ex_illegal=1, wb_en=0; then rst=0 mid-cycle -> all outputs 0 without a clock edge
